// File: rtl/sel_pipe_reg_if.sv
// Bundles the sel_pipe_reg input bus and its registered result signals.
// master: drives the channel words, select/mode and pipeline controls.
// slave : consumes them and returns the last-stage result, error flag and counter.
interface sel_pipe_reg_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int CNT_W    = 16
);
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic                      in_valid;
  logic [SEL_W-1:0]          sel;
  logic [1:0]                mode;
  logic                      en;
  logic                      clr;
  logic [WIDTH-1:0]          out_data;
  logic                      out_valid;
  logic [SEL_W-1:0]          out_chan;
  logic                      sel_err;
  logic [CNT_W-1:0]          out_count;

  modport master (
    output in_data, in_valid, sel, mode, en, clr,
    input  out_data, out_valid, out_chan, sel_err, out_count
  );

  modport slave (
    input  in_data, in_valid, sel, mode, en, clr,
    output out_data, out_valid, out_chan, sel_err, out_count
  );
endinterface

// File: rtl/sel_pipe_reg.sv
// Purpose: picks one of CHANNELS words (or their AND/OR) and carries it through a DEPTH-stage tagged pipe.
// Latency: DEPTH enabled clock edges from capture to out_valid; disabled edges do not advance the pipe.
// Backpressure: en=0 freezes every stage, sel_err and out_count; inputs are ignored while frozen.
// Ports: clk/reset (async, active-high); bus.in_data/in_valid/sel/mode/en/clr in,
//        bus.out_data/out_valid/out_chan from the last stage, bus.sel_err (sticky), bus.out_count.
module sel_pipe_reg #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int DEPTH    = 3,
  parameter int CNT_W    = 16
) (
  input logic           clk,
  input logic           reset,
  sel_pipe_reg_if.slave bus
);
  localparam logic [1:0] MODE_SEL = 2'b00;
  localparam logic [1:0] MODE_AND = 2'b01;
  localparam logic [1:0] MODE_OR  = 2'b10;

  logic [WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [SEL_W-1:0] r_tag  [DEPTH];
  logic             r_sel_err;
  logic [CNT_W-1:0] r_count;

  logic [WIDTH-1:0] w_chan_word;
  logic [WIDTH-1:0] w_and;
  logic [WIDTH-1:0] w_or;
  logic             w_hit;
  logic [WIDTH-1:0] w_data;
  logic             w_valid;
  logic [SEL_W-1:0] w_tag;
  logic             w_bad_sel;

  // Channel select and reductions. A select that matches no channel leaves
  // w_hit low and the word at zero, which also covers sel >= CHANNELS.
  always_comb begin
    w_chan_word = '0;
    w_hit       = 1'b0;
    w_and       = '1;
    w_or        = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      w_and = w_and & bus.in_data[k*WIDTH +: WIDTH];
      w_or  = w_or  | bus.in_data[k*WIDTH +: WIDTH];
      if (bus.sel == SEL_W'(k)) begin
        w_chan_word = bus.in_data[k*WIDTH +: WIDTH];
        w_hit       = 1'b1;
      end
    end
  end

  // Stage-0 candidate; mode 11 falls through to an all-zero bubble.
  always_comb begin
    w_data    = '0;
    w_valid   = 1'b0;
    w_tag     = '0;
    w_bad_sel = 1'b0;
    case (bus.mode)
      MODE_SEL: begin
        w_data    = w_chan_word;
        w_valid   = bus.in_valid;
        w_tag     = bus.sel;
        w_bad_sel = bus.in_valid & ~w_hit;
      end
      MODE_AND: begin
        w_data  = w_and;
        w_valid = bus.in_valid;
        w_tag   = '1;
      end
      MODE_OR: begin
        w_data  = w_or;
        w_valid = bus.in_valid;
        w_tag   = '1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
        r_tag[i]  <= '0;
      end
      r_valid   <= '0;
      r_sel_err <= 1'b0;
      r_count   <= '0;
    end else if (bus.clr) begin
      // Clear beats freeze: it applies whether or not en is high.
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
        r_tag[i]  <= '0;
      end
      r_valid   <= '0;
      r_sel_err <= 1'b0;
      r_count   <= '0;
    end else if (bus.en) begin
      r_data[0]  <= w_data;
      r_valid[0] <= w_valid;
      r_tag[0]   <= w_tag;
      for (int i = 1; i < DEPTH; i++) begin
        r_data[i]  <= r_data[i-1];
        r_valid[i] <= r_valid[i-1];
        r_tag[i]   <= r_tag[i-1];
      end
      if (w_bad_sel) begin
        r_sel_err <= 1'b1;
      end
      // Count the word that leaves the last stage on this edge; wraps silently.
      if (r_valid[DEPTH-1]) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign bus.out_data  = r_data[DEPTH-1];
  assign bus.out_valid = r_valid[DEPTH-1];
  assign bus.out_chan  = r_tag[DEPTH-1];
  assign bus.sel_err   = r_sel_err;
  assign bus.out_count = r_count;
endmodule

// File: tb/tb_sel_pipe_reg.sv
module tb_sel_pipe_reg;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sel_pipe_reg_if #(.WIDTH(8), .CHANNELS(4), .SEL_W(2), .CNT_W(16)) ifa ();
  sel_pipe_reg_if #(.WIDTH(8), .CHANNELS(3), .SEL_W(2), .CNT_W(4))  ifb ();

  sel_pipe_reg #(.WIDTH(8), .CHANNELS(4), .SEL_W(2), .DEPTH(3), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa)
  );
  sel_pipe_reg #(.WIDTH(8), .CHANNELS(3), .SEL_W(2), .DEPTH(3), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb)
  );

  typedef struct {
    logic [1:0]  mode;
    logic [1:0]  sel;
    logic        vld;
    logic        en;
    logic        clr;
    logic [31:0] din;
    logic [7:0]  e_data;
    logic        e_vld;
    logic [1:0]  e_chan;
    logic [15:0] e_cnt;
  } vec_t;

  localparam logic [31:0] D1 = 32'h44332211;
  localparam logic [31:0] D2 = 32'hF0F3FCFF;
  localparam int NV = 21;

  vec_t tbl [NV];
  int n_vec = 0;
  int n_err = 0;
  int got   = 0;
  logic [7:0] exp_w [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
  logic [1:0] sel_w [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

  function automatic vec_t mk(input logic [1:0] m, input logic [1:0] s, input logic v,
                              input logic e, input logic c, input logic [31:0] d,
                              input logic [7:0] ed, input logic ev, input logic [1:0] ec,
                              input logic [15:0] cnt);
    vec_t r;
    r.mode = m; r.sel = s; r.vld = v; r.en = e; r.clr = c; r.din = d;
    r.e_data = ed; r.e_vld = ev; r.e_chan = ec; r.e_cnt = cnt;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_a(input string name, input logic [7:0] d, input logic v,
                       input logic [1:0] c, input logic [15:0] cnt);
    chk({name, ".data"}, 32'(ifa.out_data), 32'(d));
    chk({name, ".vld"},  32'(ifa.out_valid), 32'(v));
    chk({name, ".chan"}, 32'(ifa.out_chan), 32'(c));
    chk({name, ".err"},  32'(ifa.sel_err), 32'd0);
    chk({name, ".cnt"},  32'(ifa.out_count), 32'(cnt));
  endtask

  task automatic collect();
    if (ifa.out_valid) begin
      if (got < 5) begin
        chk($sformatf("stream%0d.data", got), 32'(ifa.out_data), 32'(exp_w[got]));
        chk($sformatf("stream%0d.chan", got), 32'(ifa.out_chan), 32'(sel_w[got]));
      end else begin
        chk("stream_extra", 32'(got), 32'd4);
      end
      got++;
    end
  endtask

  initial begin
    // inputs           | expected outputs after the edge
    tbl[0]  = mk(2'd0, 2'd2, 1'b1, 1'b1, 1'b0, D1, 8'h00, 1'b0, 2'd0, 16'd0);
    tbl[1]  = mk(2'd0, 2'd0, 1'b0, 1'b1, 1'b0, D1, 8'h00, 1'b0, 2'd0, 16'd0);
    tbl[2]  = mk(2'd0, 2'd1, 1'b0, 1'b1, 1'b0, D1, 8'h33, 1'b1, 2'd2, 16'd0);
    tbl[3]  = mk(2'd0, 2'd3, 1'b0, 1'b1, 1'b0, D1, 8'h11, 1'b0, 2'd0, 16'd1);
    tbl[4]  = mk(2'd1, 2'd0, 1'b1, 1'b1, 1'b0, D2, 8'h22, 1'b0, 2'd1, 16'd1);
    tbl[5]  = mk(2'd2, 2'd0, 1'b1, 1'b1, 1'b0, D2, 8'h44, 1'b0, 2'd3, 16'd1);
    tbl[6]  = mk(2'd3, 2'd0, 1'b1, 1'b1, 1'b0, D2, 8'hF0, 1'b1, 2'd3, 16'd1);
    tbl[7]  = mk(2'd0, 2'd1, 1'b1, 1'b1, 1'b0, D2, 8'hFF, 1'b1, 2'd3, 16'd2);
    tbl[8]  = mk(2'd0, 2'd2, 1'b1, 1'b1, 1'b0, D2, 8'h00, 1'b0, 2'd0, 16'd3);
    tbl[9]  = mk(2'd1, 2'd0, 1'b1, 1'b0, 1'b0, D2, 8'h00, 1'b0, 2'd0, 16'd3);
    tbl[10] = mk(2'd2, 2'd0, 1'b1, 1'b0, 1'b0, D2, 8'h00, 1'b0, 2'd0, 16'd3);
    tbl[11] = mk(2'd3, 2'd0, 1'b0, 1'b1, 1'b0, D2, 8'hFC, 1'b1, 2'd1, 16'd3);
    tbl[12] = mk(2'd3, 2'd0, 1'b0, 1'b1, 1'b0, D2, 8'hF3, 1'b1, 2'd2, 16'd4);
    tbl[13] = mk(2'd0, 2'd0, 1'b1, 1'b1, 1'b1, D1, 8'h00, 1'b0, 2'd0, 16'd0);
    tbl[14] = mk(2'd3, 2'd0, 1'b0, 1'b1, 1'b0, D1, 8'h00, 1'b0, 2'd0, 16'd0);
    tbl[15] = mk(2'd3, 2'd0, 1'b0, 1'b1, 1'b0, D1, 8'h00, 1'b0, 2'd0, 16'd0);
    tbl[16] = mk(2'd0, 2'd2, 1'b1, 1'b1, 1'b0, D1, 8'h00, 1'b0, 2'd0, 16'd0);
    tbl[17] = mk(2'd0, 2'd0, 1'b1, 1'b0, 1'b1, D1, 8'h00, 1'b0, 2'd0, 16'd0);
    tbl[18] = mk(2'd3, 2'd0, 1'b0, 1'b1, 1'b0, D1, 8'h00, 1'b0, 2'd0, 16'd0);
    tbl[19] = mk(2'd3, 2'd0, 1'b0, 1'b1, 1'b0, D1, 8'h00, 1'b0, 2'd0, 16'd0);
    tbl[20] = mk(2'd3, 2'd0, 1'b0, 1'b1, 1'b0, D1, 8'h00, 1'b0, 2'd0, 16'd0);

    reset = 1'b1;
    ifa.in_data = '0; ifa.in_valid = 1'b0; ifa.sel = '0; ifa.mode = 2'd3; ifa.en = 1'b0; ifa.clr = 1'b0;
    ifb.in_data = '0; ifb.in_valid = 1'b0; ifb.sel = '0; ifb.mode = 2'd3; ifb.en = 1'b0; ifb.clr = 1'b0;
    tick();
    tick();
    chk_a("reset", 8'h00, 1'b0, 2'd0, 16'd0);
    chk("reset_b.cnt", 32'(ifb.out_count), 32'd0);
    reset = 1'b0;

    // Table-driven main sequence on the 4-channel build.
    for (int i = 0; i < NV; i++) begin
      ifa.mode = tbl[i].mode; ifa.sel = tbl[i].sel; ifa.in_valid = tbl[i].vld;
      ifa.en = tbl[i].en; ifa.clr = tbl[i].clr; ifa.in_data = tbl[i].din;
      tick();
      chk_a($sformatf("vec%0d", i), tbl[i].e_data, tbl[i].e_vld, tbl[i].e_chan, tbl[i].e_cnt);
    end

    // Five-word stream with a two-cycle stall before the fourth word.
    got = 0;
    ifa.clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) begin
        ifa.en = 1'b0; ifa.mode = 2'd1; ifa.in_valid = 1'b1;
        for (int s = 0; s < 2; s++) begin
          tick();
          chk_a($sformatf("stall%0d", s), 8'h11, 1'b1, 2'd0, 16'd0);
        end
      end
      ifa.en = 1'b1; ifa.mode = 2'd0; ifa.sel = sel_w[i]; ifa.in_valid = 1'b1; ifa.in_data = D1;
      tick();
      collect();
    end
    ifa.mode = 2'd3; ifa.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      collect();
    end
    chk("stream_words", 32'(got), 32'd5);
    chk("stream_count", 32'(ifa.out_count), 32'd5);

    // Asynchronous reset with three words in flight.
    ifa.mode = 2'd0; ifa.in_valid = 1'b1; ifa.in_data = D1;
    for (int i = 1; i < 4; i++) begin
      ifa.sel = 2'(i);
      tick();
    end
    chk_a("inflight", 8'h22, 1'b1, 2'd1, 16'd5);
    #2 reset = 1'b1;
    #1 chk_a("async_rst", 8'h00, 1'b0, 2'd0, 16'd0);
    ifa.mode = 2'd3; ifa.in_valid = 1'b0;
    #3 reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_a($sformatf("post_rst%0d", i), 8'h00, 1'b0, 2'd0, 16'd0);
    end
    ifa.en = 1'b0;

    // 3-channel build: out-of-range select, sticky error, clear flushing a word in flight.
    ifb.en = 1'b1; ifb.mode = 2'd0; ifb.sel = 2'd3; ifb.in_valid = 1'b1; ifb.in_data = 24'h332211;
    tick();
    chk("b_err_set", 32'(ifb.sel_err), 32'd1);
    ifb.mode = 2'd3; ifb.in_valid = 1'b0;
    tick();
    ifb.mode = 2'd0; ifb.sel = 2'd0; ifb.in_valid = 1'b1;
    tick();
    chk("b_oob.data", 32'(ifb.out_data), 32'd0);
    chk("b_oob.vld",  32'(ifb.out_valid), 32'd1);
    chk("b_oob.chan", 32'(ifb.out_chan), 32'd3);
    chk("b_err_sticky", 32'(ifb.sel_err), 32'd1);
    ifb.mode = 2'd3; ifb.in_valid = 1'b0; ifb.clr = 1'b1;
    tick();
    ifb.clr = 1'b0;
    chk("b_clr.err", 32'(ifb.sel_err), 32'd0);
    chk("b_clr.cnt", 32'(ifb.out_count), 32'd0);
    chk("b_clr.vld", 32'(ifb.out_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("b_flushed%0d", i), 32'(ifb.out_valid), 32'd0);
    end
    ifb.mode = 2'd0; ifb.sel = 2'd3; ifb.in_valid = 1'b0;
    tick();
    chk("b_err_novalid", 32'(ifb.sel_err), 32'd0);

    // OR across a non-power-of-two channel count.
    ifb.mode = 2'd2; ifb.in_valid = 1'b1; ifb.in_data = 24'h010204;
    tick();
    ifb.mode = 2'd3; ifb.in_valid = 1'b0;
    tick();
    tick();
    chk("b_or.data", 32'(ifb.out_data), 32'h07);
    chk("b_or.vld",  32'(ifb.out_valid), 32'd1);
    chk("b_or.chan", 32'(ifb.out_chan), 32'd3);

    // 4-bit counter wrap: 17 words.
    ifb.clr = 1'b1;
    tick();
    ifb.clr = 1'b0;
    ifb.mode = 2'd0; ifb.sel = 2'd0; ifb.in_valid = 1'b1; ifb.in_data = 24'h332211;
    for (int i = 0; i < 17; i++) tick();
    chk("b_cnt14", 32'(ifb.out_count), 32'd14);
    ifb.mode = 2'd3; ifb.in_valid = 1'b0;
    tick();
    tick();
    chk("b_cnt_wrap0", 32'(ifb.out_count), 32'd0);
    tick();
    chk("b_cnt_wrap1", 32'(ifb.out_count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
